icache: RTL



---
 rtl/icache.sv | 103 ++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache between the fetch stage and memory.
// Define ICACHE_STATS_EN to add saturating hit_count / miss_count outputs.
module icache #(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(NSETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t             state;
    logic [NSETS-1:0]   valid;
    logic [TAG_W-1:0]   tags [NSETS];
    logic [31:0]        data [NSETS];
    logic [31:0]        fill_addr;

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   fill_tag;
    logic               hit;
    logic               miss_start;
    logic               fill_done;
    logic               unused_offset;

    assign idx           = imemaddr[IDX_W+1:2];
    assign tag           = imemaddr[31:IDX_W+2];
    assign fill_idx      = fill_addr[IDX_W+1:2];
    assign fill_tag      = fill_addr[31:IDX_W+2];
    assign unused_offset = ^imemaddr[1:0];

    // Lookups only happen in IDLE, so a frame write can never race a read.
    assign hit        = (state == IDLE) && imemREN && valid[idx] && (tags[idx] == tag);
    assign miss_start = (state == IDLE) && imemREN && !hit;
    assign fill_done  = (state == FILL) && !iwait;

    assign ihit     = hit;
    assign imemload = hit ? data[idx] : 32'h0;
    assign iREN     = (state == FILL);
    assign iaddr    = fill_addr;

    // Once started, a fill always runs to completion from fill_addr, regardless of imemREN.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            valid     <= '0;
            fill_addr <= '0;
        end else begin
            if (miss_start) begin
                fill_addr <= {imemaddr[31:2], 2'b00};
                state     <= FILL;
            end
            if (fill_done) begin
                valid[fill_idx] <= 1'b1;
                state           <= IDLE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && hit_count != 32'hFFFF_FFFF) begin
                hit_count <= hit_count + 32'd1;
            end
            if (miss_start && miss_count != 32'hFFFF_FFFF) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end
`endif

endmodule
